blink_multi: RTL and testbench

BLINK_MULTI -- requirements
Module: blink_multi

---
 rtl/blink_multi_if.sv | 17 +
 rtl/blink_multi.sv | 106 ++++++++++
 tb/tb_blink_multi.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blink_multi_if.sv
// Control and status bundle for blink_multi.
// The master side drives mode and start requests. The slave side returns the LED, tick and done outputs.
interface blink_multi_if #(
    parameter int NCH     = 4,
    parameter int BURST_W = 4
);
    logic               en;
    logic [2*NCH-1:0]   mode;
    logic [NCH-1:0]     start;
    logic [BURST_W-1:0] burst_len;
    logic [NCH-1:0]     led;
    logic               flg;
    logic [NCH-1:0]     done;

    modport master (output en, mode, start, burst_len, input led, flg, done);
    modport slave  (input en, mode, start, burst_len, output led, flg, done);
endinterface

// File: rtl/blink_multi.sv
// Multi-channel LED driver with a shared prescaler.
// Each channel can be off, on, blinking, or running a counted burst of blinks.
module blink_multi #(
    parameter int CBITS   = 22,
    parameter int NCH     = 4,
    parameter int BURST_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    blink_multi_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [CBITS-1:0] cnt;
    logic             tick;

    assign tick = bus.en && (cnt == '1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            bus.flg <= 1'b0;
        end else begin
            if (bus.en)
                cnt <= cnt + 1'b1;
            bus.flg <= tick;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [1:0]         m;
        logic [1:0]         mq;
        logic               ph;
        logic               ph_n;
        logic [0:0]         st;
        logic [BURST_W-1:0] rem;
        logic               led_q;
        logic               done_q;

        assign m = bus.mode[2*i +: 2];
        // A mode change into BLINK restarts the phase, so the first edge is always a rise.
        assign ph_n = ((m != mq) ? 1'b0 : ph) ^ tick;

        always_ff @(posedge clk) begin
            if (!rst) begin
                mq     <= 2'b00;
                ph     <= 1'b0;
                st     <= IDLE;
                rem    <= '0;
                led_q  <= 1'b0;
                done_q <= 1'b0;
            end else begin
                mq     <= m;
                done_q <= 1'b0;
                case (m)
                    2'b00, 2'b01: begin
                        ph    <= 1'b0;
                        st    <= IDLE;
                        rem   <= '0;
                        led_q <= m[0];
                    end
                    2'b10: begin
                        st    <= IDLE;
                        rem   <= '0;
                        ph    <= ph_n;
                        led_q <= ph_n;
                    end
                    default: begin
                        if (st == IDLE) begin
                            ph    <= 1'b0;
                            led_q <= 1'b0;
                            if (bus.en && bus.start[i]) begin
                                if (bus.burst_len == '0)
                                    done_q <= 1'b1;
                                else begin
                                    st  <= RUN;
                                    rem <= bus.burst_len;
                                end
                            end
                        end else if (tick) begin
                            // Each falling edge of the phase consumes one period of the burst.
                            if (ph) begin
                                ph    <= 1'b0;
                                led_q <= 1'b0;
                                if (rem == BURST_W'(1)) begin
                                    st     <= IDLE;
                                    rem    <= '0;
                                    done_q <= 1'b1;
                                end else begin
                                    rem <= rem - 1'b1;
                                end
                            end else begin
                                ph    <= 1'b1;
                                led_q <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end

        assign bus.led[i]  = led_q;
        assign bus.done[i] = done_q;
    end
endmodule

// File: tb/tb_blink_multi.sv
// Testbench for blink_multi with CBITS=3.
// A reference model counts ticks since each mode entry or burst start, and the bench compares it with the DUT every cycle.
module tb_blink_multi;
    localparam int CBITS = 3;
    localparam int NCH   = 4;
    localparam int BW    = 4;
    localparam int PER   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    blink_multi_if #(.NCH(NCH), .BURST_W(BW)) bus ();
    blink_multi #(.CBITS(CBITS), .NCH(NCH), .BURST_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: led levels follow the parity of the tick count since the mode entry or the burst start.
    int         ecnt;
    int         nt  [NCH];
    int         bl  [NCH];
    bit         act [NCH];
    logic [1:0] pm  [NCH];
    logic [1:0] mm;
    bit         tk, ent;
    logic [NCH-1:0] e_led, e_done;
    logic           e_flg;

    always @(posedge clk) begin
        if (!rst) begin
            ecnt = 0; e_led = '0; e_done = '0; e_flg = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                act[i] = 0; nt[i] = 0; bl[i] = 0; pm[i] = 2'b00;
            end
        end else begin
            tk = bus.en && (ecnt % PER == PER - 1);
            if (bus.en) ecnt++;
            e_flg = tk;
            for (int i = 0; i < NCH; i++) begin
                mm = bus.mode[2*i +: 2];
                ent = (mm != pm[i]);
                pm[i] = mm;
                e_done[i] = 1'b0;
                case (mm)
                    2'b00: begin act[i] = 0; e_led[i] = 1'b0; end
                    2'b01: begin act[i] = 0; e_led[i] = 1'b1; end
                    2'b10: begin
                        act[i] = 0;
                        if (ent) nt[i] = 0;
                        if (tk) nt[i]++;
                        e_led[i] = (nt[i] % 2 == 1);
                    end
                    default: begin
                        if (!act[i]) begin
                            e_led[i] = 1'b0;
                            if (bus.en && bus.start[i]) begin
                                if (bus.burst_len == 0) e_done[i] = 1'b1;
                                else begin act[i] = 1; bl[i] = int'(bus.burst_len); nt[i] = 0; end
                            end
                        end else begin
                            if (tk) nt[i]++;
                            if (nt[i] == 2 * bl[i]) begin
                                act[i] = 0; e_done[i] = 1'b1; e_led[i] = 1'b0;
                            end else begin
                                e_led[i] = (nt[i] % 2 == 1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; bus.en = 1'b1; bus.mode = '0; bus.start = '0; bus.burst_len = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.led, bus.flg, bus.done} !== '0) begin
                errors++;
                $display("FAIL reset_state: got led=%b flg=%b done=%b, want all zero", bus.led, bus.flg, bus.done);
            end
        end
    endtask

    task automatic test_flg();
        int first = 0, second = 0;
        rst = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.led, bus.flg, bus.done} !== {e_led, e_flg, e_done}) begin
                errors++;
                $display("FAIL flg_model: got %b/%b/%b want %b/%b/%b", bus.led, bus.flg, bus.done, e_led, e_flg, e_done);
            end
            if (bus.flg === 1'b1) begin
                if (first == 0) first = k; else if (second == 0) second = k;
            end
        end
        checks++;
        if (first != 8 || second != 16) begin
            errors++;
            $display("FAIL flg_timing: got first=%0d second=%0d, want 8 and 16", first, second);
        end
    endtask

    task automatic test_blink_on();
        int run = 0, full = 0;
        bus.mode = 8'b00_00_01_10;
        for (int k = 0; k < 56; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.led, bus.flg, bus.done} !== {e_led, e_flg, e_done}) begin
                errors++;
                $display("FAIL blink_model: got %b/%b/%b want %b/%b/%b", bus.led, bus.flg, bus.done, e_led, e_flg, e_done);
            end
            if (bus.led[1] !== 1'b1) begin
                errors++;
                $display("FAIL on_level: got led1=%b want 1", bus.led[1]);
            end
            if (bus.led[0] === 1'b1) run++;
            else if (run != 0) begin
                checks++;
                if (run != PER) begin
                    errors++;
                    $display("FAIL blink_width: got %0d high cycles want %0d", run, PER);
                end
                full++; run = 0;
            end
        end
        checks++;
        if (full < 2) begin
            errors++;
            $display("FAIL blink_count: got %0d full pulses want at least 2", full);
        end
    endtask

    task automatic test_burst();
        int rises = 0, dones = 0;
        logic prev;
        bus.mode[5:4] = 2'b11; bus.burst_len = 4'd3; bus.start[2] = 1'b1;
        prev = bus.led[2];
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            bus.start[2] = 1'b0;
            checks++;
            if ({bus.led, bus.flg, bus.done} !== {e_led, e_flg, e_done}) begin
                errors++;
                $display("FAIL burst_model: got %b/%b/%b want %b/%b/%b", bus.led, bus.flg, bus.done, e_led, e_flg, e_done);
            end
            if (bus.led[2] && !prev) rises++;
            if (bus.done[2]) dones++;
            prev = bus.led[2];
        end
        checks++;
        if (rises != 3 || dones != 1 || bus.led[2] !== 1'b0) begin
            errors++;
            $display("FAIL burst3: got rises=%0d dones=%0d led2=%b, want 3, 1, 0", rises, dones, bus.led[2]);
        end
    endtask

    task automatic test_burst_zero();
        int rises = 0;
        bus.mode[7:6] = 2'b11; bus.burst_len = 4'd0; bus.start[3] = 1'b1;
        @(negedge clk);
        bus.start[3] = 1'b0;
        checks++;
        if (bus.done[3] !== 1'b1 || bus.led[3] !== 1'b0) begin
            errors++;
            $display("FAIL burst0_done: got done3=%b led3=%b want 1, 0", bus.done[3], bus.led[3]);
        end
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.led, bus.flg, bus.done} !== {e_led, e_flg, e_done}) begin
                errors++;
                $display("FAIL burst0_model: got %b/%b/%b want %b/%b/%b", bus.led, bus.flg, bus.done, e_led, e_flg, e_done);
            end
            if (bus.led[3]) rises++;
        end
        checks++;
        if (rises != 0) begin
            errors++;
            $display("FAIL burst0_led: got %0d high cycles want 0", rises);
        end
    endtask

    task automatic test_abort();
        int rises = 0, dones = 0, k = 0;
        logic prev;
        bus.mode[5:4] = 2'b11; bus.burst_len = 4'd5; bus.start[2] = 1'b1;
        prev = bus.led[2];
        while (rises < 2 && k < 100) begin
            @(negedge clk);
            bus.start[2] = 1'b0;
            if (bus.led[2] && !prev) rises++;
            prev = bus.led[2]; k++;
        end
        checks++;
        if (rises != 2) begin
            errors++;
            $display("FAIL abort_wait: got %0d rises within budget want 2", rises);
        end
        bus.mode[5:4] = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.led[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_led: got led2=%b want 0", bus.led[2]);
        end
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (bus.done[2]) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_done: got %0d done pulses want 0", dones);
        end
        bus.mode[5:4] = 2'b11; bus.burst_len = 4'd1; bus.start[2] = 1'b1;
        rises = 0; prev = bus.led[2];
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            bus.start[2] = 1'b0;
            checks++;
            if ({bus.led, bus.flg, bus.done} !== {e_led, e_flg, e_done}) begin
                errors++;
                $display("FAIL restart_model: got %b/%b/%b want %b/%b/%b", bus.led, bus.flg, bus.done, e_led, e_flg, e_done);
            end
            if (bus.led[2] && !prev) rises++;
            if (bus.done[2]) dones++;
            prev = bus.led[2];
        end
        checks++;
        if (rises != 1 || dones != 1) begin
            errors++;
            $display("FAIL restart1: got rises=%0d dones=%0d want 1, 1", rises, dones);
        end
    endtask

    task automatic test_freeze_reset();
        logic [NCH-1:0] snap;
        bus.mode = 8'b00_11_00_10; bus.burst_len = 4'd7; bus.start = 4'b0100;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus.start = '0;
        end
        bus.en = 1'b0;
        snap = bus.led;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (bus.led !== snap || bus.flg !== 1'b0 || bus.done !== '0) begin
                errors++;
                $display("FAIL freeze: got led=%b flg=%b done=%b want led=%b flg=0 done=0", bus.led, bus.flg, bus.done, snap);
            end
        end
        bus.en = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({bus.led, bus.flg, bus.done} !== '0) begin
                errors++;
                $display("FAIL midreset: got led=%b flg=%b done=%b want all zero", bus.led, bus.flg, bus.done);
            end
        end
        rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.led, bus.flg, bus.done} !== {e_led, e_flg, e_done} || bus.done[2] !== 1'b0) begin
                errors++;
                $display("FAIL postreset: got %b/%b/%b want %b/%b/%b", bus.led, bus.flg, bus.done, e_led, e_flg, e_done);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.led, bus.flg, bus.done} !== {e_led, e_flg, e_done}) begin
                errors++;
                $display("FAIL random_model: cyc %0d got %b/%b/%b want %b/%b/%b", k, bus.led, bus.flg, bus.done, e_led, e_flg, e_done);
            end
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(23) == 0) bus.mode[2*i +: 2] = 2'($urandom_range(3));
            end
            bus.start     = NCH'($urandom) & NCH'($urandom);
            bus.burst_len = BW'($urandom_range(3));
            bus.en        = ($urandom_range(7) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_flg();
        test_blink_on();
        test_burst();
        test_burst_zero();
        test_abort();
        test_freeze_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
